// File: rtl/id_ctrl_pkg.sv
// id_ctrl_pkg
// Shared definitions for the ID-stage controller: MIPS opcode/funct
// constants, ALU and branch codes, HI/LO operation codes, the registered
// control bundle (ctrl_t) and the combinational instruction decoder.
// No ports; imported by id_control_stage and md_busy_tracker.

package id_ctrl_pkg;

    localparam int ALU_W = 4;
    localparam int REG_W = 5;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_ANDI  = 6'h0c;
    localparam logic [5:0] OP_ORI   = 6'h0d;
    localparam logic [5:0] OP_XORI  = 6'h0e;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;

    localparam logic [5:0] FN_SLL   = 6'h00;
    localparam logic [5:0] FN_SRL   = 6'h02;
    localparam logic [5:0] FN_SRA   = 6'h03;
    localparam logic [5:0] FN_SLLV  = 6'h04;
    localparam logic [5:0] FN_SRLV  = 6'h06;
    localparam logic [5:0] FN_SRAV  = 6'h07;
    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_MFHI  = 6'h10;
    localparam logic [5:0] FN_MFLO  = 6'h12;
    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_MULTU = 6'h19;
    localparam logic [5:0] FN_DIV   = 6'h1a;
    localparam logic [5:0] FN_DIVU  = 6'h1b;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_SUBU  = 6'h23;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_XOR   = 6'h26;
    localparam logic [5:0] FN_NOR   = 6'h27;
    localparam logic [5:0] FN_SLT   = 6'h2a;

    localparam logic [ALU_W-1:0] ALU_AND  = 4'b0000;
    localparam logic [ALU_W-1:0] ALU_OR   = 4'b0001;
    localparam logic [ALU_W-1:0] ALU_ADD  = 4'b0010;
    localparam logic [ALU_W-1:0] ALU_SRA  = 4'b0011;
    localparam logic [ALU_W-1:0] ALU_SLL  = 4'b0100;
    localparam logic [ALU_W-1:0] ALU_SRL  = 4'b0101;
    localparam logic [ALU_W-1:0] ALU_SUB  = 4'b0110;
    localparam logic [ALU_W-1:0] ALU_SLT  = 4'b0111;
    localparam logic [ALU_W-1:0] ALU_NOR  = 4'b1100;
    localparam logic [ALU_W-1:0] ALU_XOR  = 4'b1101;
    localparam logic [ALU_W-1:0] ALU_NONE = 4'b1111;

    localparam logic [1:0] BR_NONE = 2'b00;
    localparam logic [1:0] BR_BEQ  = 2'b01;
    localparam logic [1:0] BR_BNE  = 2'b10;
    localparam logic [1:0] BR_JR   = 2'b11;

    localparam logic [1:0] MD_MULT  = 2'b00;
    localparam logic [1:0] MD_MULTU = 2'b01;
    localparam logic [1:0] MD_DIV   = 2'b10;
    localparam logic [1:0] MD_DIVU  = 2'b11;

    typedef struct packed {
        logic             mem_to_reg;
        logic             reg_write;
        logic             mem_write;
        logic             mem_read;
        logic             alu_src;
        logic             reg_dst;
        logic             jump;
        logic             jal;
        logic             jr;
        logic             shift_src;
        logic [1:0]       branch;
        logic [ALU_W-1:0] alu_ctrl;
        logic [REG_W-1:0] dest;
        logic             md_start;
        logic [1:0]       md_op;
        logic             illegal;
    } ctrl_t;

    // Decoder result: the control bundle plus operand-usage flags that only
    // the hazard logic needs (never registered).
    typedef struct packed {
        ctrl_t ctrl;
        logic  rs_read;
        logic  rt_read;
        logic  md_use;
    } dec_t;

    function automatic ctrl_t bubble_ctrl();
        ctrl_t c;
        c          = '0;
        c.alu_ctrl = ALU_NONE;
        return c;
    endfunction

    function automatic dec_t decode(input logic [31:0] instr, input logic muldiv_en);
        dec_t       d;
        logic       ill;
        logic [5:0] op;
        logic [5:0] fn;
        logic [4:0] rt;
        logic [4:0] rd;
        op        = instr[31:26];
        fn        = instr[5:0];
        rt        = instr[20:16];
        rd        = instr[15:11];
        d.ctrl    = bubble_ctrl();
        d.rs_read = 1'b0;
        d.rt_read = 1'b0;
        d.md_use  = 1'b0;
        ill       = 1'b0;
        case (op)
            OP_RTYPE: begin
                d.rs_read        = 1'b1;
                d.rt_read        = 1'b1;
                d.ctrl.reg_write = 1'b1;
                d.ctrl.reg_dst   = 1'b1;
                d.ctrl.dest      = rd;
                case (fn)
                    FN_ADD, FN_ADDU: d.ctrl.alu_ctrl = ALU_ADD;
                    FN_SUB, FN_SUBU: d.ctrl.alu_ctrl = ALU_SUB;
                    FN_AND:          d.ctrl.alu_ctrl = ALU_AND;
                    FN_OR:           d.ctrl.alu_ctrl = ALU_OR;
                    FN_XOR:          d.ctrl.alu_ctrl = ALU_XOR;
                    FN_NOR:          d.ctrl.alu_ctrl = ALU_NOR;
                    FN_SLT:          d.ctrl.alu_ctrl = ALU_SLT;
                    FN_SLLV:         d.ctrl.alu_ctrl = ALU_SLL;
                    FN_SRLV:         d.ctrl.alu_ctrl = ALU_SRL;
                    FN_SRAV:         d.ctrl.alu_ctrl = ALU_SRA;
                    // Immediate shifts take the amount from shamt, so rs is not an operand.
                    FN_SLL: begin
                        d.ctrl.alu_ctrl  = ALU_SLL;
                        d.ctrl.shift_src = 1'b1;
                        d.rs_read        = 1'b0;
                    end
                    FN_SRL: begin
                        d.ctrl.alu_ctrl  = ALU_SRL;
                        d.ctrl.shift_src = 1'b1;
                        d.rs_read        = 1'b0;
                    end
                    FN_SRA: begin
                        d.ctrl.alu_ctrl  = ALU_SRA;
                        d.ctrl.shift_src = 1'b1;
                        d.rs_read        = 1'b0;
                    end
                    FN_JR: begin
                        d.ctrl.reg_write = 1'b0;
                        d.ctrl.reg_dst   = 1'b0;
                        d.ctrl.dest      = '0;
                        d.ctrl.jr        = 1'b1;
                        d.ctrl.branch    = BR_JR;
                    end
                    // ALU idles; the datapath muxes HI/LO onto the write-back bus.
                    FN_MFHI, FN_MFLO: begin
                        if (muldiv_en) begin
                            d.rs_read = 1'b0;
                            d.md_use  = 1'b1;
                        end else begin
                            ill = 1'b1;
                        end
                    end
                    FN_MULT, FN_MULTU, FN_DIV, FN_DIVU: begin
                        if (muldiv_en) begin
                            d.ctrl.reg_write = 1'b0;
                            d.ctrl.reg_dst   = 1'b0;
                            d.ctrl.dest      = '0;
                            d.ctrl.md_start  = 1'b1;
                            d.ctrl.md_op     = fn[1:0];
                            d.md_use         = 1'b1;
                        end else begin
                            ill = 1'b1;
                        end
                    end
                    default: ill = 1'b1;
                endcase
            end
            OP_J: d.ctrl.jump = 1'b1;
            OP_JAL: begin
                d.ctrl.jump      = 1'b1;
                d.ctrl.jal       = 1'b1;
                d.ctrl.reg_write = 1'b1;
                d.ctrl.dest      = 5'd31;
                d.ctrl.alu_ctrl  = ALU_ADD;
            end
            OP_BEQ, OP_BNE: begin
                d.ctrl.branch   = (op == OP_BEQ) ? BR_BEQ : BR_BNE;
                d.ctrl.alu_ctrl = ALU_SUB;
                d.rs_read       = 1'b1;
                d.rt_read       = 1'b1;
            end
            OP_LW: begin
                d.ctrl.alu_src    = 1'b1;
                d.ctrl.mem_to_reg = 1'b1;
                d.ctrl.reg_write  = 1'b1;
                d.ctrl.mem_read   = 1'b1;
                d.ctrl.alu_ctrl   = ALU_ADD;
                d.ctrl.dest       = rt;
                d.rs_read         = 1'b1;
            end
            OP_SW: begin
                d.ctrl.alu_src   = 1'b1;
                d.ctrl.mem_write = 1'b1;
                d.ctrl.alu_ctrl  = ALU_ADD;
                d.rs_read        = 1'b1;
                d.rt_read        = 1'b1;
            end
            OP_ADDI, OP_ADDIU, OP_ANDI, OP_ORI, OP_XORI: begin
                d.ctrl.alu_src   = 1'b1;
                d.ctrl.reg_write = 1'b1;
                d.ctrl.dest      = rt;
                d.rs_read        = 1'b1;
                case (op)
                    OP_ANDI: d.ctrl.alu_ctrl = ALU_AND;
                    OP_ORI:  d.ctrl.alu_ctrl = ALU_OR;
                    OP_XORI: d.ctrl.alu_ctrl = ALU_XOR;
                    default: d.ctrl.alu_ctrl = ALU_ADD;
                endcase
            end
            default: ill = 1'b1;
        endcase
        if (ill) begin
            d.ctrl         = bubble_ctrl();
            d.ctrl.illegal = 1'b1;
            d.rs_read      = 1'b0;
            d.rt_read      = 1'b0;
            d.md_use       = 1'b0;
        end
        return d;
    endfunction

endpackage

// File: rtl/id_control_stage_md_busy_tracker.sv
// md_busy_tracker
// Tracks HI/LO occupancy after a mult/div issue.
// Ports: clk, reset (sync, active-high), start (issue edge), busy (registered,
// high for exactly MD_LATENCY cycles starting the cycle after start is sampled).
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | HI/LO free; start loads the down-counter with MD_LATENCY-1
// BUSY  | operation in flight; counter decrements, exits after reaching 0

module md_busy_tracker #(
    parameter int MD_LATENCY = 32
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    output logic busy
);
    import id_ctrl_pkg::*;

    localparam int CNT_W = (MD_LATENCY > 1) ? $clog2(MD_LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MD_LATENCY - 1);

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_BUSY = 1'b1
    } md_state_t;

    md_state_t        state_d, state_q;
    logic [CNT_W-1:0] cnt_d, cnt_q;
    logic             busy_d, busy_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            MD_IDLE: begin
                if (start) begin
                    state_d = MD_BUSY;
                    cnt_d   = CNT_INIT;
                end
            end
            MD_BUSY: begin
                if (cnt_q == '0) begin
                    state_d = MD_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = MD_IDLE;
        endcase
        busy_d = (state_d == MD_BUSY);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= MD_IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
        end
    end

    assign busy = busy_q;

endmodule

// File: rtl/id_control_stage.sv
// id_control_stage
// Registered ID-stage controller: decodes the IF/ID instruction into the
// ID/EX control register, inserts bubbles on load-use and HI/LO hazards,
// kills the decoding instruction on flush, and tracks mult/div occupancy.
// Ports: clk, reset (sync, active-high), instr, flush, ex_rd_i (EX dest
// feedback) in; stall (combinational), md_busy and ex_* controls out.

module id_control_stage
    import id_ctrl_pkg::*;
#(
    parameter int ALU_CTRL_W     = 4,
    parameter int REG_ADDR_W     = 5,
    parameter int MD_LATENCY     = 32,
    parameter bit SUPPORT_MULDIV = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [31:0]           instr,
    input  logic                  flush,
    input  logic [REG_ADDR_W-1:0] ex_rd_i,
    output logic                  stall,
    output logic                  md_busy,
    output logic                  ex_mem_to_reg,
    output logic                  ex_reg_write,
    output logic                  ex_mem_write,
    output logic                  ex_mem_read,
    output logic                  ex_alu_src,
    output logic                  ex_reg_dst,
    output logic                  ex_jump,
    output logic                  ex_jal,
    output logic                  ex_jr,
    output logic                  ex_shift_src,
    output logic [1:0]            ex_branch,
    output logic [ALU_CTRL_W-1:0] ex_alu_ctrl,
    output logic [REG_ADDR_W-1:0] ex_dest,
    output logic                  ex_md_start,
    output logic [1:0]            ex_md_op,
    output logic                  ex_illegal
);

    dec_t                  dec;
    ctrl_t                 ctrl_d, ctrl_q;
    logic                  md_busy_w;
    logic                  load_use;
    logic                  md_hazard;
    logic [REG_ADDR_W-1:0] rs_w, rt_w;

    assign rs_w = REG_ADDR_W'(instr[25:21]);
    assign rt_w = REG_ADDR_W'(instr[20:16]);

    always_comb begin
        dec = decode(instr, SUPPORT_MULDIV);

        // Loads into $0 never produce a value worth waiting for.
        load_use = ctrl_q.mem_read && (ex_rd_i != '0) &&
                   ((dec.rs_read && (ex_rd_i == rs_w)) ||
                    (dec.rt_read && (ex_rd_i == rt_w)));
        md_hazard = SUPPORT_MULDIV && md_busy_w && dec.md_use;

        // A flushed instruction is discarded anyway, so it must not hold the front end.
        stall = (load_use || md_hazard) && !flush && !reset;

        if (flush || stall) begin
            ctrl_d = bubble_ctrl();
        end else begin
            ctrl_d = dec.ctrl;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_q <= bubble_ctrl();
        end else begin
            ctrl_q <= ctrl_d;
        end
    end

    generate
        if (SUPPORT_MULDIV) begin : g_md
            md_busy_tracker #(
                .MD_LATENCY(MD_LATENCY)
            ) u_md_busy_tracker (
                .clk  (clk),
                .reset(reset),
                .start(ctrl_d.md_start),
                .busy (md_busy_w)
            );
        end else begin : g_no_md
            assign md_busy_w = 1'b0;
        end
    endgenerate

    assign md_busy       = md_busy_w;
    assign ex_mem_to_reg = ctrl_q.mem_to_reg;
    assign ex_reg_write  = ctrl_q.reg_write;
    assign ex_mem_write  = ctrl_q.mem_write;
    assign ex_mem_read   = ctrl_q.mem_read;
    assign ex_alu_src    = ctrl_q.alu_src;
    assign ex_reg_dst    = ctrl_q.reg_dst;
    assign ex_jump       = ctrl_q.jump;
    assign ex_jal        = ctrl_q.jal;
    assign ex_jr         = ctrl_q.jr;
    assign ex_shift_src  = ctrl_q.shift_src;
    assign ex_branch     = ctrl_q.branch;
    // "none" stays all-ones whatever the configured code width.
    assign ex_alu_ctrl   = (ctrl_q.alu_ctrl == ALU_NONE) ? '1 : ALU_CTRL_W'(ctrl_q.alu_ctrl);
    assign ex_dest       = REG_ADDR_W'(ctrl_q.dest);
    assign ex_md_start   = ctrl_q.md_start;
    assign ex_md_op      = ctrl_q.md_op;
    assign ex_illegal    = ctrl_q.illegal;

endmodule

// File: tb/tb_id_control_stage.sv
// Testbench for id_control_stage (MD_LATENCY = 4). Directed steps; the
// expected ID/EX bundle for each step is queued when the instruction is
// driven and compared after the following clock edge.

module tb_id_control_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instr;
    logic        flush;
    logic [4:0]  ex_rd_i;
    logic        stall, md_busy;
    logic        ex_mem_to_reg, ex_reg_write, ex_mem_write, ex_mem_read;
    logic        ex_alu_src, ex_reg_dst, ex_jump, ex_jal, ex_jr, ex_shift_src;
    logic [1:0]  ex_branch;
    logic [3:0]  ex_alu_ctrl;
    logic [4:0]  ex_dest;
    logic        ex_md_start;
    logic [1:0]  ex_md_op;
    logic        ex_illegal;

    always #5 clk = ~clk;

    assign ex_rd_i = ex_dest;

    id_control_stage #(
        .ALU_CTRL_W(4),
        .REG_ADDR_W(5),
        .MD_LATENCY(4),
        .SUPPORT_MULDIV(1'b1)
    ) dut (
        .clk(clk), .reset(reset), .instr(instr), .flush(flush), .ex_rd_i(ex_rd_i),
        .stall(stall), .md_busy(md_busy),
        .ex_mem_to_reg(ex_mem_to_reg), .ex_reg_write(ex_reg_write),
        .ex_mem_write(ex_mem_write), .ex_mem_read(ex_mem_read),
        .ex_alu_src(ex_alu_src), .ex_reg_dst(ex_reg_dst), .ex_jump(ex_jump),
        .ex_jal(ex_jal), .ex_jr(ex_jr), .ex_shift_src(ex_shift_src),
        .ex_branch(ex_branch), .ex_alu_ctrl(ex_alu_ctrl), .ex_dest(ex_dest),
        .ex_md_start(ex_md_start), .ex_md_op(ex_md_op), .ex_illegal(ex_illegal)
    );

    typedef struct packed {
        logic       m2r, rw, mw, mr, asrc, rdst, jmp, jal, jr, shs;
        logic [1:0] br;
        logic [3:0] alu;
        logic [4:0] dest;
        logic       mds;
        logic [1:0] mdop;
        logic       ill;
        logic       busy;
    } exp_t;

    exp_t obs;
    assign obs = {ex_mem_to_reg, ex_reg_write, ex_mem_write, ex_mem_read, ex_alu_src,
                  ex_reg_dst, ex_jump, ex_jal, ex_jr, ex_shift_src, ex_branch,
                  ex_alu_ctrl, ex_dest, ex_md_start, ex_md_op, ex_illegal, md_busy};

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic logic [31:0] r_ins(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [4:0] sh,
                                          input logic [5:0] fn);
        return {6'h00, rs, rt, rd, sh, fn};
    endfunction

    function automatic logic [31:0] i_ins(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic exp_t bub(input logic busy);
        exp_t e;
        e      = '0;
        e.alu  = 4'b1111;
        e.busy = busy;
        return e;
    endfunction

    function automatic exp_t f_r(input logic [3:0] alu, input logic [4:0] rd, input logic sh);
        exp_t e;
        e      = bub(1'b0);
        e.rw   = 1'b1;
        e.rdst = 1'b1;
        e.alu  = alu;
        e.dest = rd;
        e.shs  = sh;
        return e;
    endfunction

    function automatic exp_t f_lw(input logic [4:0] rt);
        exp_t e;
        e      = bub(1'b0);
        e.m2r  = 1'b1;
        e.rw   = 1'b1;
        e.mr   = 1'b1;
        e.asrc = 1'b1;
        e.alu  = 4'b0010;
        e.dest = rt;
        return e;
    endfunction

    function automatic exp_t f_imm(input logic [3:0] alu, input logic [4:0] rt);
        exp_t e;
        e      = bub(1'b0);
        e.rw   = 1'b1;
        e.asrc = 1'b1;
        e.alu  = alu;
        e.dest = rt;
        return e;
    endfunction

    task automatic step(input logic [31:0] i, input logic f, input logic r,
                        input logic exp_stall, input exp_t e, input string tag);
        exp_t want;
        instr = i;
        flush = f;
        reset = r;
        #1;
        n_checks++;
        assert (stall === exp_stall) else begin
            n_fail++;
            $error("FAIL %s_stall: observed %b expected %b", tag, stall, exp_stall);
        end
        sb.push_back(e);
        @(posedge clk);
        #1;
        want = sb.pop_front();
        n_checks++;
        assert (obs === want) else begin
            n_fail++;
            $error("FAIL %s_ctrl: observed %h expected %h", tag, obs, want);
        end
    endtask

    localparam logic [5:0] LW = 6'h23;
    localparam logic [5:0] SW = 6'h2b;

    initial begin
        exp_t e;
        logic [31:0] add3, add6_dep, lw5, mflo7;
        add3     = r_ins(5'd1, 5'd2, 5'd3, 5'd0, 6'h20);
        add6_dep = r_ins(5'd5, 5'd2, 5'd6, 5'd0, 6'h20);
        lw5      = i_ins(LW, 5'd1, 5'd5, 16'h0000);
        mflo7    = r_ins(5'd0, 5'd0, 5'd7, 5'd0, 6'h12);

        reset = 1'b1;
        flush = 1'b0;
        instr = '0;
        @(posedge clk);
        #1;

        step(add3, 1'b0, 1'b1, 1'b0, bub(1'b0), "reset_hold");
        step(add3, 1'b0, 1'b0, 1'b0, f_r(4'b0010, 5'd3, 1'b0), "add_after_reset");

        step(lw5,      1'b0, 1'b0, 1'b0, f_lw(5'd5), "lw5_a");
        step(add6_dep, 1'b0, 1'b0, 1'b1, bub(1'b0), "load_use_stall");
        step(add6_dep, 1'b0, 1'b0, 1'b0, f_r(4'b0010, 5'd6, 1'b0), "load_use_issue");

        step(lw5, 1'b0, 1'b0, 1'b0, f_lw(5'd5), "lw5_b");
        step(r_ins(5'd0, 5'd2, 5'd6, 5'd0, 6'h20), 1'b0, 1'b0, 1'b0,
             f_r(4'b0010, 5'd6, 1'b0), "no_dependency");

        step(i_ins(LW, 5'd1, 5'd0, 16'h0000), 1'b0, 1'b0, 1'b0, f_lw(5'd0), "lw_to_r0");
        step(r_ins(5'd0, 5'd0, 5'd6, 5'd0, 6'h20), 1'b0, 1'b0, 1'b0,
             f_r(4'b0010, 5'd6, 1'b0), "r0_no_stall");

        step(lw5,      1'b0, 1'b0, 1'b0, f_lw(5'd5), "lw5_c");
        step(add6_dep, 1'b1, 1'b0, 1'b0, bub(1'b0), "flush_over_hazard");

        step(lw5, 1'b0, 1'b0, 1'b0, f_lw(5'd5), "lw5_d");
        step(i_ins(SW, 5'd1, 5'd5, 16'h0004), 1'b0, 1'b0, 1'b1, bub(1'b0), "sw_rt_stall");
        e      = bub(1'b0);
        e.mw   = 1'b1;
        e.asrc = 1'b1;
        e.alu  = 4'b0010;
        step(i_ins(SW, 5'd1, 5'd5, 16'h0004), 1'b0, 1'b0, 1'b0, e, "sw_issue");

        step(lw5, 1'b0, 1'b0, 1'b0, f_lw(5'd5), "lw5_e");
        step(i_ins(6'h08, 5'd9, 5'd5, 16'h0001), 1'b0, 1'b0, 1'b0,
             f_imm(4'b0010, 5'd5), "addi_rt_not_read");

        step(lw5,      1'b0, 1'b0, 1'b0, f_lw(5'd5), "lw5_f");
        step(add6_dep, 1'b0, 1'b1, 1'b0, bub(1'b0), "reset_masks_stall");

        step(r_ins(5'd0, 5'd2, 5'd4, 5'd3, 6'h00), 1'b0, 1'b0, 1'b0,
             f_r(4'b0100, 5'd4, 1'b1), "sll");
        step(r_ins(5'd1, 5'd2, 5'd4, 5'd0, 6'h07), 1'b0, 1'b0, 1'b0,
             f_r(4'b0011, 5'd4, 1'b0), "srav");
        step(r_ins(5'd1, 5'd2, 5'd8, 5'd0, 6'h27), 1'b0, 1'b0, 1'b0,
             f_r(4'b1100, 5'd8, 1'b0), "nor");

        e     = bub(1'b0);
        e.br  = 2'b01;
        e.alu = 4'b0110;
        step(i_ins(6'h04, 5'd1, 5'd2, 16'h0010), 1'b0, 1'b0, 1'b0, e, "beq");
        e    = bub(1'b0);
        e.jr = 1'b1;
        e.br = 2'b11;
        step(r_ins(5'd31, 5'd0, 5'd0, 5'd0, 6'h08), 1'b0, 1'b0, 1'b0, e, "jr");
        e     = bub(1'b0);
        e.jmp = 1'b1;
        step({6'h02, 26'h0000040}, 1'b0, 1'b0, 1'b0, e, "j");
        e      = bub(1'b0);
        e.jmp  = 1'b1;
        e.jal  = 1'b1;
        e.rw   = 1'b1;
        e.dest = 5'd31;
        e.alu  = 4'b0010;
        step({6'h03, 26'h0000080}, 1'b0, 1'b0, 1'b0, e, "jal");
        e     = bub(1'b0);
        e.ill = 1'b1;
        step({6'h3f, 26'h0000000}, 1'b0, 1'b0, 1'b0, e, "illegal_op");
        step(i_ins(6'h0d, 5'd1, 5'd9, 16'h0007), 1'b0, 1'b0, 1'b0,
             f_imm(4'b0001, 5'd9), "ori_clears_illegal");

        e      = bub(1'b1);
        e.mds  = 1'b1;
        e.mdop = 2'b00;
        step(r_ins(5'd1, 5'd2, 5'd0, 5'd0, 6'h18), 1'b0, 1'b0, 1'b0, e, "mult_issue");
        step(mflo7, 1'b0, 1'b0, 1'b1, bub(1'b1), "mflo_stall1");
        step(mflo7, 1'b0, 1'b0, 1'b1, bub(1'b1), "mflo_stall2");
        step(mflo7, 1'b0, 1'b0, 1'b1, bub(1'b1), "mflo_stall3");
        step(mflo7, 1'b0, 1'b0, 1'b1, bub(1'b0), "mflo_stall4");
        e      = bub(1'b0);
        e.rw   = 1'b1;
        e.rdst = 1'b1;
        e.dest = 5'd7;
        step(mflo7, 1'b0, 1'b0, 1'b0, e, "mflo_issue");

        e      = bub(1'b1);
        e.mds  = 1'b1;
        e.mdop = 2'b11;
        step(r_ins(5'd1, 5'd2, 5'd0, 5'd0, 6'h1b), 1'b0, 1'b0, 1'b0, e, "divu_issue");
        step(r_ins(5'd0, 5'd0, 5'd8, 5'd0, 6'h10), 1'b0, 1'b1, 1'b0, bub(1'b0),
             "reset_aborts_busy");
        e      = bub(1'b0);
        e.rw   = 1'b1;
        e.rdst = 1'b1;
        e.dest = 5'd8;
        step(r_ins(5'd0, 5'd0, 5'd8, 5'd0, 6'h10), 1'b0, 1'b0, 1'b0, e, "mfhi_after_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/id_control_stage.md
Name: id_control_stage

Overview:
- Parametrised, registered successor to the combinational decoder: decodes the IF/ID instruction and drives the ID/EX control register.
- Adds load-use hazard detection with bubble insertion, and branch/jump flush.
- Adds a multi-cycle multiply/divide tracker (mult/multu/div/divu, mfhi/mflo) that stalls decode while HI/LO are busy.
- Sits between the IF/ID register and the execute stage; its stall output freezes the PC and the IF/ID register.

Parameters:
- ALU_CTRL_W, 4, width of the ALU control code (existing encodings: and 0000, or 0001, add 0010, sra 0011, sll 0100, srl 0101, sub 0110, slt 0111, nor 1100, xor 1101, none 1111).
- REG_ADDR_W, 5, register-index width.
- MD_LATENCY, 32, cycles a mult/div occupies HI/LO (legal range 1..64).
- SUPPORT_MULDIV, 1, when 0 the mult/div/mfhi/mflo functs decode as illegal and md_busy ties to 0.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- instr  in  32  instruction held in the IF/ID register.
- flush  in  1  kill the decoding instruction (taken branch, jump, jr).
- ex_rd_i  in  REG_ADDR_W  destination register of the instruction currently in EX (fed back from ex_dest).
- stall  out  1  combinational; freeze PC and IF/ID this cycle.
- md_busy  out  1  registered; HI/LO unit busy.
- ex_mem_to_reg, ex_reg_write, ex_mem_write, ex_mem_read, ex_alu_src, ex_reg_dst, ex_jump, ex_jal, ex_jr, ex_shift_src  out  1 each  registered control signals.
- ex_branch  out  2  00 none, 01 beq, 10 bne, 11 jr.
- ex_alu_ctrl  out  ALU_CTRL_W  registered ALU code.
- ex_dest  out  REG_ADDR_W  resolved write register: rd, rt, or 31 for jal; 0 when ex_reg_write=0.
- ex_md_start  out  1  one-cycle pulse; start the HI/LO unit.
- ex_md_op  out  2  00 mult, 01 multu, 10 div, 11 divu.
- ex_illegal  out  1  registered; unknown opcode/funct.

Behaviour:
- Reset: all ex_* outputs 0 except ex_alu_ctrl = all-ones; md_busy 0; counter 0; stall 0 during reset.
- Decode table: identical to the existing control encodings for add/addu/sub/subu/and/or/xor/nor/slt/sll/sllv/srl/srlv/sra/srav/jr/beq/bne/lw/sw/addi/addiu/andi/ori/xori/j/jal. Correction: sw asserts MemRead=0.
- Unknown instruction: bubble controls plus ex_illegal=1 for one cycle.
- Latency: 1 cycle; controls appear on ex_* at the clock edge after instr is presented.
- Bubble: all write/memory/branch/jump/md_start signals 0, ex_alu_ctrl all-ones, ex_dest 0, ex_illegal 0.
- Load-use hazard = ex_mem_read & ex_rd_i != 0 & (ex_rd_i == rs when rs is read, or ex_rd_i == rt when rt is read). rt counts as read for R-type, beq, bne and sw only.
- Mult/div hazard = SUPPORT_MULDIV & md_busy & instr is mult/div/mfhi/mflo.
- stall = (load-use hazard | mult/div hazard) & ~flush & ~reset.
- Priority at each edge:
  - reset → reset values.
  - flush → bubble.
  - stall → bubble.
  - otherwise → decoded controls.
- mfhi (funct 0x10) / mflo (0x12): reg_write=1, dest=rd, ex_alu_ctrl all-ones (result sourced from HI/LO by the datapath).
- mult/div (funct 0x18..0x1b): reg_write=0; ex_md_start=1 and ex_md_op set on the issuing edge.
- Busy FSM states:
  - IDLE: on the issue edge → BUSY, counter = MD_LATENCY-1.
  - BUSY: counter decrements each cycle; leave BUSY on the edge after counter reaches 0.
  - md_busy is 1 for exactly MD_LATENCY cycles, starting the cycle ex_md_start is high.
- mult issued while md_busy is impossible, because stall covers it.
- flush never aborts an in-progress BUSY; only reset does, returning to IDLE with md_busy=0 on the next edge.

Decomposition:
- Shared package id_ctrl_pkg: opcode constants, funct constants, ALU code constants, branch-code constants, md_op constants, and the bubble control bundle (packed struct ctrl_t).
- Sub-module md_busy_tracker (IDLE/BUSY FSM and counter, parameter MD_LATENCY).
- Decode is a combinational function in the package; the top holds the ID/EX register and the hazard logic.

Test Plan:
- Reset mid-stream: reset asserted with `add $3,$1,$2` at instr → next edge all ex_* at reset values, ex_alu_ctrl=4'b1111. Deassert → next edge ex_alu_ctrl=0010, ex_dest=3, ex_reg_write=1.
- Load-use: `lw $5,0($1)` then `add $6,$5,$2` → stall=1 for one cycle, ID/EX holds a bubble, then add issues. Same sequence with `add $6,$0,$2` → no stall.
- Load to $0: `lw $0,0($1)` then `add $6,$0,$0` → stall=0.
- Flush over hazard: load-use condition with flush=1 → stall=0, bubble registered, ex_reg_write=0.
- Multiply occupancy, MD_LATENCY=4: `mult $1,$2` → ex_md_start=1 for 1 cycle, ex_md_op=00, md_busy high for 4 cycles. `mflo $7` presented the next cycle → stall for exactly 4 cycles, then ex_dest=7, ex_reg_write=1.
- jal and illegal opcode: `jal` → ex_dest=31, ex_jal=1, ex_jump=1, ex_alu_ctrl=0010. Opcode 0x3F → bubble controls plus ex_illegal=1 for one cycle.
